jtvigil_pcm: RTL and testbench

- PCM sample fetch unit inside the sound subsystem. It sits between the sound Z80 port decoder and the SDRAM PCM ROM slot (pcm_addr/pcm_cs/pcm_data/pcm_ok).
- Holds the 16-bit sample address written by the CPU and prefetches the addressed byte into a one-byte buffer.
- Returns that byte on a CPU sample read, then auto-increments the address and refetches.
- Holds the DAC register and outputs it as signed 16-bit audio with a sample strobe.

---
 rtl/jtvigil_snd_pkg.sv | 19 +
 rtl/jtvigil_pcm.sv | 136 +++++++++++++
 tb/tb_jtvigil_pcm.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/jtvigil_snd_pkg.sv
// Shared definitions for the Vigilante sound subsystem: PCM fetch states,
// sound port offsets and the DAC bias.
package jtvigil_snd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2
    } pcm_st_e;

    // Sound CPU port offsets decoded upstream of the PCM unit
    localparam logic [2:0] ADDRL = 3'd0;
    localparam logic [2:0] ADDRH = 3'd1;
    localparam logic [2:0] DAC   = 3'd2;
    localparam logic [2:0] SMP   = 3'd4;

    localparam logic [7:0] DAC_BIAS = 8'h80;

endpackage

// File: rtl/jtvigil_pcm.sv
// PCM sample fetch unit: CPU-written sample address, one-byte prefetch buffer
// with auto-increment on read, and the DAC register driving signed audio.
module jtvigil_pcm
    import jtvigil_snd_pkg::*;
#(
    parameter int GUARD = 2,
    parameter int DACW  = 16
)(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cen,
    input  logic [7:0]      din,
    input  logic            addrl_we,
    input  logic            addrh_we,
    input  logic            smp_rd,
    input  logic            dac_we,
    output logic [7:0]      dout,
    output logic            wait_n,
    output logic [15:0]     pcm_addr,
    output logic            pcm_cs,
    input  logic [7:0]      pcm_data,
    input  logic            pcm_ok,
    output logic [DACW-1:0] snd,
    output logic            sample
);

    localparam int GW = (GUARD < 1) ? 1 : $clog2(GUARD + 1);

    pcm_st_e          st_q, st_d;
    logic [15:0]      addr_q, addr_d;
    logic [GW-1:0]    guard_q, guard_d;
    logic [7:0]       buf_q, buf_d;
    logic [7:0]       dout_q, dout_d;
    logic             pend_q, pend_d;
    logic [DACW-1:0]  snd_q, snd_d;
    logic             sample_q, sample_d;

    logic addr_wr, rd, rd_miss;

    assign addr_wr = cen & (addrl_we | addrh_we);
    assign rd      = cen & smp_rd;
    // A read that cannot be served from the buffer this cycle stalls the CPU
    assign rd_miss = rd & ((st_q != VALID) | addr_wr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q     <= IDLE;
            addr_q   <= '0;
            guard_q  <= '0;
            buf_q    <= '0;
            dout_q   <= '0;
            pend_q   <= 1'b0;
            snd_q    <= '0;
            sample_q <= 1'b0;
        end else begin
            st_q     <= st_d;
            addr_q   <= addr_d;
            guard_q  <= guard_d;
            buf_q    <= buf_d;
            dout_q   <= dout_d;
            pend_q   <= pend_d;
            snd_q    <= snd_d;
            sample_q <= sample_d;
        end
    end

    always_comb begin
        st_d    = st_q;
        addr_d  = addr_q;
        guard_d = guard_q;
        buf_d   = buf_q;
        dout_d  = dout_q;
        pend_d  = pend_q;
        if (addr_wr) begin
            // Restarting the guard discards any ok still pending for the old address
            if (addrl_we) addr_d[7:0]  = din;
            if (addrh_we) addr_d[15:8] = din;
            st_d    = FETCH;
            guard_d = GW'(GUARD);
            if (rd) pend_d = 1'b1;
        end else begin
            case (st_q)
                IDLE: begin
                    if (rd) begin
                        pend_d  = 1'b1;
                        st_d    = FETCH;
                        guard_d = GW'(GUARD);
                    end
                end
                FETCH: begin
                    if (rd) pend_d = 1'b1;
                    if (guard_q != '0) begin
                        guard_d = guard_q - GW'(1);
                    end else if (pcm_ok) begin
                        buf_d = pcm_data;
                        if (pend_q || rd) begin
                            // Waiting read: hand the byte over and refetch at once
                            dout_d  = pcm_data;
                            pend_d  = 1'b0;
                            addr_d  = addr_q + 16'd1;
                            guard_d = GW'(GUARD);
                        end else begin
                            st_d = VALID;
                        end
                    end
                end
                VALID: begin
                    if (rd) begin
                        dout_d  = buf_q;
                        addr_d  = addr_q + 16'd1;
                        st_d    = FETCH;
                        guard_d = GW'(GUARD);
                    end
                end
                default: st_d = IDLE;
            endcase
        end
    end

    always_comb begin
        snd_d    = snd_q;
        sample_d = 1'b0;
        if (cen && dac_we) begin
            snd_d    = {din ^ DAC_BIAS, {(DACW-8){1'b0}}};
            sample_d = 1'b1;
        end
    end

    assign pcm_addr = addr_q;
    assign pcm_cs   = (st_q == FETCH);
    assign dout     = dout_q;
    assign wait_n   = ~(pend_q | rd_miss);
    assign snd      = snd_q;
    assign sample   = sample_q;

endmodule

// File: tb/tb_jtvigil_pcm.sv
// Directed bench for jtvigil_pcm with a 3-clk ROM model returning addr[7:0]^0x5A.
module tb_jtvigil_pcm;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cen = 1'b1;
    logic [7:0]  din = '0;
    logic        addrl_we = 1'b0, addrh_we = 1'b0, smp_rd = 1'b0, dac_we = 1'b0;
    logic [7:0]  dout;
    logic        wait_n;
    logic [15:0] pcm_addr;
    logic        pcm_cs;
    logic [7:0]  pcm_data;
    logic        pcm_ok;
    logic [15:0] snd;
    logic        sample;

    int nchk = 0;
    int nfail = 0;

    jtvigil_pcm #(.GUARD(2), .DACW(16)) dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .din(din),
        .addrl_we(addrl_we), .addrh_we(addrh_we), .smp_rd(smp_rd), .dac_we(dac_we),
        .dout(dout), .wait_n(wait_n), .pcm_addr(pcm_addr), .pcm_cs(pcm_cs),
        .pcm_data(pcm_data), .pcm_ok(pcm_ok), .snd(snd), .sample(sample)
    );

    always #5 clk = ~clk;

    // ROM model: ok once address has been stable with cs high for 3 clks
    logic [15:0] prev_a = '0;
    logic [1:0]  lat = '0;
    logic        stale = 1'b0;
    always @(posedge clk) begin
        prev_a <= pcm_addr;
        if (!pcm_cs || pcm_addr != prev_a) lat <= 2'd0;
        else if (lat != 2'd3)              lat <= lat + 2'd1;
    end
    assign pcm_ok   = stale | (pcm_cs && pcm_addr == prev_a && lat == 2'd3);
    assign pcm_data = stale ? 8'hEE : (pcm_addr[7:0] ^ 8'h5A);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_addr(input logic hi, input logic [7:0] v);
        din = v;
        addrl_we = ~hi;
        addrh_we = hi;
        tick();
        addrl_we = 1'b0;
        addrh_we = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (pcm_cs && n < 20) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, pcm_cs}, 32'd0);
    endtask

    task automatic wait_release(input string tag);
        int n;
        n = 0;
        while (!wait_n && n < 20) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, wait_n}, 32'd1);
    endtask

    task automatic rd_valid(input string tag, input logic [7:0] exp_d, input logic [15:0] exp_a);
        smp_rd = 1'b1;
        #1;
        chk({tag, "_waitn"}, {31'd0, wait_n}, 32'd1);
        tick();
        smp_rd = 1'b0;
        chk({tag, "_dout"}, {24'd0, dout}, {24'd0, exp_d});
        chk({tag, "_addr"}, {16'd0, pcm_addr}, {16'd0, exp_a});
        chk({tag, "_cs"}, {31'd0, pcm_cs}, 32'd1);
    endtask

    task automatic dac(input logic [7:0] v, input logic [15:0] exp_s, input string tag);
        din = v;
        dac_we = 1'b1;
        tick();
        dac_we = 1'b0;
        chk({tag, "_snd"}, {16'd0, snd}, {16'd0, exp_s});
        chk({tag, "_smp1"}, {31'd0, sample}, 32'd1);
        tick();
        chk({tag, "_smp0"}, {31'd0, sample}, 32'd0);
        chk({tag, "_hold"}, {16'd0, snd}, {16'd0, exp_s});
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_addr", {16'd0, pcm_addr}, 32'h0);
        chk("rst_cs", {31'd0, pcm_cs}, 32'd0);
        chk("rst_dout", {24'd0, dout}, 32'h0);
        chk("rst_waitn", {31'd0, wait_n}, 32'd1);
        chk("rst_snd", {16'd0, snd}, 32'h0);
        chk("rst_sample", {31'd0, sample}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic prefetch then hit
        wr_addr(1'b0, 8'h34);
        chk("t1_cs_lat", {31'd0, pcm_cs}, 32'd1);
        wr_addr(1'b1, 8'h12);
        chk("t1_addr", {16'd0, pcm_addr}, 32'h1234);
        wait_valid("t1_valid");
        rd_valid("t1_rd", 8'h6E, 16'h1235);

        // Read straight after the address write stalls until data lands
        wr_addr(1'b0, 8'h34);
        smp_rd = 1'b1;
        #1;
        chk("t2_waitn_comb", {31'd0, wait_n}, 32'd0);
        tick();
        smp_rd = 1'b0;
        chk("t2_waitn_pend", {31'd0, wait_n}, 32'd0);
        wait_release("t2_release");
        chk("t2_dout", {24'd0, dout}, 32'h6E);
        chk("t2_addr", {16'd0, pcm_addr}, 32'h1235);
        chk("t2_cs", {31'd0, pcm_cs}, 32'd1);

        // Address wrap
        wr_addr(1'b0, 8'hFF);
        wr_addr(1'b1, 8'hFF);
        wait_valid("t3_valid0");
        rd_valid("t3_rd0", 8'hA5, 16'h0000);
        wait_valid("t3_valid1");
        chk("t3_wrap_addr", {16'd0, pcm_addr}, 32'h0000);
        rd_valid("t3_rd1", 8'h5A, 16'h0001);

        // Stale ok inside the guard window is discarded
        wr_addr(1'b1, 8'h12);
        tick();
        wr_addr(1'b0, 8'h80);
        stale = 1'b1;
        tick();
        tick();
        stale = 1'b0;
        wait_valid("t4_valid");
        chk("t4_addr", {16'd0, pcm_addr}, 32'h1280);
        rd_valid("t4_rd", 8'hDA, 16'h1281);

        // Address write and read in the same cycle: read targets new address
        din = 8'h10;
        addrl_we = 1'b1;
        smp_rd = 1'b1;
        #1;
        chk("t5_waitn_comb", {31'd0, wait_n}, 32'd0);
        tick();
        addrl_we = 1'b0;
        smp_rd = 1'b0;
        wait_release("t5_release");
        chk("t5_dout", {24'd0, dout}, 32'h4A);
        chk("t5_addr", {16'd0, pcm_addr}, 32'h1211);

        // DAC
        dac(8'h00, 16'h8000, "dac00");
        dac(8'h80, 16'h0000, "dac80");
        dac(8'hFF, 16'h7F00, "dacFF");
        cen = 1'b0;
        din = 8'h55;
        dac_we = 1'b1;
        tick();
        dac_we = 1'b0;
        chk("dac_nocen_snd", {16'd0, snd}, 32'h7F00);
        chk("dac_nocen_smp", {31'd0, sample}, 32'd0);
        cen = 1'b1;

        // Async reset mid-fetch with a pending read
        wr_addr(1'b0, 8'h00);
        smp_rd = 1'b1;
        tick();
        smp_rd = 1'b0;
        chk("t6_cs_pre", {31'd0, pcm_cs}, 32'd1);
        chk("t6_waitn_pre", {31'd0, wait_n}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("t6_cs_rst", {31'd0, pcm_cs}, 32'd0);
        chk("t6_waitn_rst", {31'd0, wait_n}, 32'd1);
        chk("t6_snd_rst", {16'd0, snd}, 32'h0);
        chk("t6_addr_rst", {16'd0, pcm_addr}, 32'h0);
        #1;
        rst_n = 1'b1;
        tick();
        tick();
        chk("t6_idle_cs", {31'd0, pcm_cs}, 32'd0);
        chk("t6_idle_waitn", {31'd0, wait_n}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
